// File: rtl/view_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : view_ctrl
// Purpose  : Turns the pointer sprite position and the zoom / unzoom buttons
//            into Mandelbrot view parameters (complex centre, per-pixel step,
//            zoom depth). It also requests a new frame from the renderer
//            through a start/busy handshake.
//
// Ports    : CLK          system clock
//            RESET        synchronous, active-high reset
//            zoom_btn     raw asynchronous zoom-in button
//            unzoom_btn   raw asynchronous zoom-out button
//            sprite_x/y   pointer top-left corner in pixels
//            render_busy  renderer is drawing a frame
//            render_start one-cycle frame request
//            center_re/im signed Q4.28 view centre
//            step         signed Q4.28 complex distance per pixel
//            zoom_level   current zoom depth, 0..MAX_ZOOM
//
// Revision : 1.0 - initial release
// ============================================================================
module view_ctrl #(
    parameter int COORD_W         = 32,
    parameter int FRAC            = 28,
    parameter int H_RES           = 800,
    parameter int V_RES           = 600,
    parameter int SPRITE          = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_ZOOM        = 20,
    parameter logic signed [COORD_W-1:0] INIT_RE   = -134217728,
    parameter logic signed [COORD_W-1:0] INIT_IM   = 0,
    parameter logic signed [COORD_W-1:0] INIT_STEP = 1006633
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      zoom_btn,
    input  logic                      unzoom_btn,
    input  logic [25:0]               sprite_x,
    input  logic [25:0]               sprite_y,
    input  logic                      render_busy,
    output logic                      render_start,
    output logic signed [COORD_W-1:0] center_re,
    output logic signed [COORD_W-1:0] center_im,
    output logic signed [COORD_W-1:0] step,
    output logic [4:0]                zoom_level
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_MAX = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0] c_MAX_ZOOM = 5'(MAX_ZOOM);

    // Offsets that move the sprite corner to its centre and then make the
    // result relative to the screen centre.
    localparam logic signed [COORD_W-1:0] c_DX_OFF = COORD_W'(SPRITE/2 - H_RES/2);
    localparam logic signed [COORD_W-1:0] c_DY_OFF = COORD_W'(SPRITE/2 - V_RES/2);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CALC  = 3'd1;
    localparam logic [2:0] c_APPLY = 3'd2;
    localparam logic [2:0] c_SCALE = 3'd3;
    localparam logic [2:0] c_WAIT  = 3'd4;

    localparam logic c_OP_IN  = 1'b0;
    localparam logic c_OP_OUT = 1'b1;

    // The fixed-point format must leave at least one integer bit.
    if (FRAC >= COORD_W || FRAC < 1) begin : g_frac_invalid
        $error("view_ctrl: FRAC must lie in 1..COORD_W-1");
    end

    // ------------------------------------------------------------------
    // Button conditioning: bit 0 = zoom, bit 1 = unzoom
    // ------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_rise;

    assign w_raw = {unzoom_btn, zoom_btn};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic              r_s1;
        logic              r_s2;
        logic              r_db;
        logic              r_db_d;
        logic [c_DB_W-1:0] r_cnt;

        // The counter measures how long the synchronised level has
        // disagreed with the accepted level; any agreement restarts it.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                r_s1   <= 1'b0;
                r_s2   <= 1'b0;
                r_db   <= 1'b0;
                r_db_d <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_s1   <= w_raw[gi];
                r_s2   <= r_s1;
                r_db_d <= r_db;
                if (r_s2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_MAX) begin
                    r_db  <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_DB_W'(1);
                end
            end
        end

        // Only presses generate events; releases are silent.
        assign w_rise[gi] = r_db & ~r_db_d;
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]                r_state;
    logic [2:0]                w_next;
    logic                      r_op;
    logic signed [COORD_W-1:0] r_center_re;
    logic signed [COORD_W-1:0] r_center_im;
    logic signed [COORD_W-1:0] r_step;
    logic signed [COORD_W-1:0] r_mul_x;
    logic signed [COORD_W-1:0] r_mul_y;
    logic [4:0]                r_zoom_level;
    logic                      r_render_start;

    logic                      w_go_in;
    logic                      w_go_out;
    logic signed [COORD_W-1:0] w_dx;
    logic signed [COORD_W-1:0] w_dy;
    logic signed [COORD_W-1:0] w_mul_x;
    logic signed [COORD_W-1:0] w_mul_y;

    // Zoom-in has priority; a simultaneous unzoom is simply discarded.
    assign w_go_in  = (r_state == c_IDLE) && w_rise[0] && (r_zoom_level < c_MAX_ZOOM);
    assign w_go_out = (r_state == c_IDLE) && !w_go_in && w_rise[1] &&
                      (r_zoom_level != 5'd0);

    assign w_dx = $signed(COORD_W'(sprite_x)) + c_DX_OFF;
    assign w_dy = $signed(COORD_W'(sprite_y)) + c_DY_OFF;

    // Integer pixel offset times a Q4.28 step is already Q4.28; only the
    // low COORD_W bits are kept, matching the wrap-around centre update.
    assign w_mul_x = w_dx * r_step;
    assign w_mul_y = w_dy * r_step;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_go_in || w_go_out) w_next = c_CALC;
            c_CALC:  w_next = c_APPLY;
            c_APPLY: w_next = c_SCALE;
            c_SCALE: w_next = c_WAIT;
            c_WAIT:  if (!render_busy) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_op           <= c_OP_IN;
            r_center_re    <= INIT_RE;
            r_center_im    <= INIT_IM;
            r_step         <= INIT_STEP;
            r_mul_x        <= '0;
            r_mul_y        <= '0;
            r_zoom_level   <= 5'd0;
            r_render_start <= 1'b0;
        end else begin
            r_render_start <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_go_in) begin
                        r_op <= c_OP_IN;
                    end else if (w_go_out) begin
                        r_op <= c_OP_OUT;
                    end
                end
                c_CALC: begin
                    r_mul_x <= w_mul_x;
                    r_mul_y <= w_mul_y;
                end
                c_APPLY: begin
                    // Screen y grows downward, imaginary axis grows upward.
                    r_center_re <= r_center_re + r_mul_x;
                    r_center_im <= r_center_im - r_mul_y;
                end
                c_SCALE: begin
                    if (r_op == c_OP_IN) begin
                        r_step       <= r_step >>> 1;
                        r_zoom_level <= r_zoom_level + 5'd1;
                    end else begin
                        r_step       <= r_step <<< 1;
                        r_zoom_level <= r_zoom_level - 5'd1;
                    end
                end
                c_WAIT: begin
                    if (!render_busy) begin
                        r_render_start <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign render_start = r_render_start;
    assign center_re    = r_center_re;
    assign center_im    = r_center_im;
    assign step         = r_step;
    assign zoom_level   = r_zoom_level;

endmodule
`default_nettype wire

// File: tb/tb_view_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_view_ctrl
// Purpose  : Self-checking bench for view_ctrl. Each expected frame request
//            carries the view parameters it must present; a monitor pairs
//            every render_start pulse with the oldest expected entry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_view_ctrl;

    localparam int COORD_W = 32;
    localparam logic [31:0] c_INIT_RE   = 32'hF800_0000;  // -134217728
    localparam logic [31:0] c_INIT_IM   = 32'd0;
    localparam logic [31:0] c_INIT_STEP = 32'd1006633;

    logic                      CLK = 1'b0;
    logic                      RESET = 1'b1;
    logic                      zoom_btn = 1'b0;
    logic                      unzoom_btn = 1'b0;
    logic [25:0]               sprite_x = 26'd392;
    logic [25:0]               sprite_y = 26'd292;
    logic                      render_busy = 1'b0;
    logic                      render_start;
    logic signed [COORD_W-1:0] center_re;
    logic signed [COORD_W-1:0] center_im;
    logic signed [COORD_W-1:0] step;
    logic [4:0]                zoom_level;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
        logic [31:0] st;
        logic [4:0]  lvl;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    view_ctrl #(
        .COORD_W         (32),
        .FRAC            (28),
        .H_RES           (800),
        .V_RES           (600),
        .SPRITE          (16),
        .DEBOUNCE_CYCLES (4),
        .MAX_ZOOM        (3),
        .INIT_RE         (-134217728),
        .INIT_IM         (0),
        .INIT_STEP       (1006633)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .zoom_btn     (zoom_btn),
        .unzoom_btn   (unzoom_btn),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .render_busy  (render_busy),
        .render_start (render_start),
        .center_re    (center_re),
        .center_im    (center_im),
        .step         (step),
        .zoom_level   (zoom_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] re, input logic [31:0] im,
                        input logic [31:0] st, input logic [4:0] lvl);
        exp_t e;
        e.re  = re;
        e.im  = im;
        e.st  = st;
        e.lvl = lvl;
        q_exp.push_back(e);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_center_re"}, center_re, c_INIT_RE);
        chk({tag, "_center_im"}, center_im, c_INIT_IM);
        chk({tag, "_step"}, step, c_INIT_STEP);
        chk({tag, "_zoom_level"}, 32'(zoom_level), 32'd0);
        chk({tag, "_render_start"}, 32'(render_start), 32'd0);
    endtask

    // Hold RESET for n cycles, checking reset values each cycle, then expect
    // exactly one frame request carrying the reset view.
    task automatic do_reset(input int n);
        RESET = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick(1);
            chk_reset_vals("reset");
        end
        push(c_INIT_RE, c_INIT_IM, c_INIT_STEP, 5'd0);
        RESET = 1'b0;
        tick(6);
    endtask

    // Drive the buttons for n cycles, release, and let the debouncers and
    // the FSM settle.
    task automatic press(input logic zin, input logic zout, input int n);
        zoom_btn   = zin;
        unzoom_btn = zout;
        tick(n);
        zoom_btn   = 1'b0;
        unzoom_btn = 1'b0;
        tick(24);
    endtask

    // Monitor: every frame request must match the oldest expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (RESET) begin
            chk("start_during_reset", 32'(render_start), 32'd0);
        end
        if (render_start === 1'b1) begin
            if (q_exp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_render_start: got pulse at %0t expected none", $time);
            end else begin
                e = q_exp.pop_front();
                chk("frame_center_re", center_re, e.re);
                chk("frame_center_im", center_im, e.im);
                chk("frame_step", step, e.st);
                chk("frame_zoom_level", 32'(zoom_level), 32'(e.lvl));
            end
        end
    end

    initial begin
        // Reset and the initial frame request.
        do_reset(3);

        // Centred zoom-in: centre unchanged, step halved.
        sprite_x = 26'd392;
        sprite_y = 26'd292;
        push(c_INIT_RE, 32'd0, 32'd503316, 5'd1);
        press(1'b1, 1'b0, 10);

        // Corner zoom-in from the reset view: dx=-392, dy=-292.
        do_reset(3);
        sprite_x = 26'd0;
        sprite_y = 26'd0;
        push(-32'sd528817864, 32'sd293936836, 32'd503316, 5'd1);
        press(1'b1, 1'b0, 10);

        // A 3-cycle glitch must not be accepted.
        press(1'b1, 1'b0, 3);
        chk("glitch_center_re", center_re, -32'sd528817864);
        chk("glitch_step", step, 32'd503316);
        chk("glitch_zoom_level", 32'(zoom_level), 32'd1);

        // Unzoom at level 0 is ignored.
        do_reset(3);
        press(1'b0, 1'b1, 10);
        chk("unzoom_l0_level", 32'(zoom_level), 32'd0);
        chk("unzoom_l0_step", step, c_INIT_STEP);

        // Four presses: the level saturates at 3, the 4th press is silent.
        sprite_x = 26'd392;
        sprite_y = 26'd292;
        push(c_INIT_RE, 32'd0, 32'd503316, 5'd1);
        push(c_INIT_RE, 32'd0, 32'd251658, 5'd2);
        push(c_INIT_RE, 32'd0, 32'd125829, 5'd3);
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 10);
        chk("max_zoom_level", 32'(zoom_level), 32'd3);
        chk("max_zoom_step", step, 32'd125829);

        // Handshake: a busy renderer holds the request back.
        render_busy = 1'b1;
        press(1'b0, 1'b1, 10);
        chk("busy_step", step, 32'd251658);
        chk("busy_zoom_level", 32'(zoom_level), 32'd2);
        // Unzoom while waiting is dropped.
        press(1'b0, 1'b1, 10);
        chk("wait_drop_level", 32'(zoom_level), 32'd2);
        chk("wait_drop_step", step, 32'd251658);
        push(c_INIT_RE, 32'd0, 32'd251658, 5'd2);
        render_busy = 1'b0;
        tick(6);

        // Back to level 1, then both buttons at once: zoom-in wins.
        push(c_INIT_RE, 32'd0, 32'd503316, 5'd1);
        press(1'b0, 1'b1, 10);
        push(c_INIT_RE, 32'd0, 32'd251658, 5'd2);
        press(1'b1, 1'b1, 10);
        chk("both_zoom_level", 32'(zoom_level), 32'd2);
        chk("both_step", step, 32'd251658);

        // Reset while the centre update is in flight (APPLY cycle).
        sprite_x = 26'd0;
        sprite_y = 26'd0;
        zoom_btn = 1'b1;
        tick(8);
        RESET    = 1'b1;
        zoom_btn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk_reset_vals("midreset");
        end
        push(c_INIT_RE, c_INIT_IM, c_INIT_STEP, 5'd0);
        RESET = 1'b0;
        tick(12);
        chk("midreset_level_after", 32'(zoom_level), 32'd0);
        chk("midreset_re_after", center_re, c_INIT_RE);

        chk("pending_frames", 32'(q_exp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
